// File: rtl/gates_in_debounce.sv
// Two-channel switch conditioner: 2-flop synchroniser, counter-based debounce,
// and registered one-cycle rise/fall strobes per channel.

module gates_in_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSw,
    output logic oLvl,
    output logic oRise,
    output logic oFall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // State is implied by the counter: cnt==0 with s2==lvl is STABLE,
    // any s2/lvl mismatch is COUNT.
    always_comb begin
        s1_d   = iSw;
        s2_d   = s1_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            lvl_d  = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign oLvl  = lvl_q;
    assign oRise = rise_q;
    assign oFall = fall_q;
endmodule

module gates_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSwA,
    input  logic iSwB,
    output logic oA,
    output logic oB,
    output logic oRiseA,
    output logic oFallA,
    output logic oRiseB,
    output logic oFallB
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] sw;
    logic [NUM_LANES-1:0] lvl;
    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] fall;

    assign sw = {iSwB, iSwA};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
        gates_in_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .iClk (iClk),
            .iRst (iRst),
            .iSw  (sw[i]),
            .oLvl (lvl[i]),
            .oRise(rise[i]),
            .oFall(fall[i])
        );
    end

    assign oA     = lvl[0];
    assign oB     = lvl[1];
    assign oRiseA = rise[0];
    assign oFallA = fall[0];
    assign oRiseB = rise[1];
    assign oFallB = fall[1];
endmodule

// File: tb/tb_gates_in_debounce.sv
// Directed bench for gates_in_debounce with DEBOUNCE_CYCLES=4: a clean step
// shows on the outputs 6 edges after the first edge that samples it.

module tb_gates_in_debounce;
    logic iClk = 1'b0;
    logic iRst;
    logic iSwA, iSwB;
    logic oA, oB, oRiseA, oFallA, oRiseB, oFallB;
    logic [5:0] obs;

    int checks = 0;
    int errors = 0;

    gates_in_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iSwA  (iSwA),
        .iSwB  (iSwB),
        .oA    (oA),
        .oB    (oB),
        .oRiseA(oRiseA),
        .oFallA(oFallA),
        .oRiseB(oRiseB),
        .oFallB(oFallB)
    );

    always #5 iClk = ~iClk;

    // {oA, oRiseA, oFallA, oB, oRiseB, oFallB}
    assign obs = {oA, oRiseA, oFallA, oB, oRiseB, oFallB};

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        iRst = 1'b1; iSwA = 1'b1; iSwB = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %b expected %b", k, obs, 6'b000000);
            end
        end
        iRst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 6) ? 6'b000000 : (k == 6) ? 6'b110000 : 6'b100000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [5:0] exp;
        iSwA = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 6) ? 6'b100000 : (k == 6) ? 6'b001000 : 6'b000000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 10; k++) begin
            iSwA = (k <= 3);
            step();
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b expected %b", k, obs, 6'b000000);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] exp;
        for (int k = 0; k < 12; k++) begin
            iSwA = ((k / 2) % 2) == 0;
            step();
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %b expected %b", k, obs, 6'b000000);
            end
        end
        iSwA = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k < 6) ? 6'b000000 : (k == 6) ? 6'b110000 : 6'b100000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_independence();
        logic [5:0] exp;
        iSwA = 1'b0; iSwB = 1'b0;
        repeat (8) step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL indep_setup: got %b expected %b", obs, 6'b000000);
        end
        iSwA = 1'b1; iSwB = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 6) ? 6'b000000 : (k == 6) ? 6'b110110 : 6'b100100;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL indep_step edge %0d: got %b expected %b", k, obs, exp);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            iSwB = !(k <= 2);
            step();
            checks++;
            if (obs !== 6'b100100) begin
                errors++;
                $display("FAIL indep_glitchB edge %0d: got %b expected %b", k, obs, 6'b100100);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        iSwA = 1'b0; iSwB = 1'b0;
        repeat (8) step();
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL midrst_setup: got %b expected %b", obs, 6'b000000);
        end
        iSwA = 1'b1;
        repeat (5) step();   // edges 3..5 are counting edges
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL midrst_counting: got %b expected %b", obs, 6'b000000);
        end
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k < 6) ? 6'b000000 : (k == 6) ? 6'b110000 : 6'b100000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_release edge %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL async_pre: got %b expected %b", obs, 6'b100000);
        end
        iRst = 1'b1;
        #2;   // still well before the next rising edge
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL async_clear: got %b expected %b", obs, 6'b000000);
        end
        step();
        iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1; iSwA = 1'b0; iSwB = 1'b0;
        test_reset();
        test_release();
        test_glitch();
        test_bounce();
        test_independence();
        test_reset_mid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
